// File: rtl/fir_pkg.sv
// Shared FIR definitions: the default sample/coefficient width and filter length,
// the serial engine's state encoding, and the accumulator width rule.
package fir_pkg;

    localparam int FIR_N    = 16;
    localparam int FIR_TAPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // AW guard bits absorb the growth from summing TAPS = 2**AW full-scale products.
    function automatic int accw(input int n, input int aw);
        return 2 * n + aw;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed N x N multiplier feeding a sign-extended ACCW accumulator.
// clr has priority over en.
module fir_mac_unit #(
    parameter int N    = 16,
    parameter int ACCW = 35
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    output logic [ACCW-1:0] acc
);

    logic signed [2*N-1:0] prod;
    logic [ACCW-1:0]       prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACCW-2*N){prod[2*N-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/fir_tap_mac.sv
// Time-multiplexed FIR: one multiply-accumulate per clock over a circular sample
// history, newest tap first, full-precision result on a valid/ready output.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int N    = FIR_N,
    parameter int TAPS = FIR_TAPS,
    parameter int AW   = $clog2(TAPS),
    parameter int ACCW = accw(N, AW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [N-1:0]    coef_data,
    output logic [ACCW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and out_data is held while out_valid is high.

    localparam logic [AW:0] K_END = (AW+1)'(TAPS);

    fir_state_e      state;
    logic [N-1:0]    hist [TAPS];
    logic [N-1:0]    coef [TAPS];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   newest;
    logic [AW:0]     k;
    logic [AW-1:0]   tap;
    logic [ACCW-1:0] acc;
    logic            mac_clr;
    logic            mac_en;

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;
    assign tap       = k[AW-1:0];
    assign mac_clr   = (state == IDLE) && in_valid;
    assign mac_en    = (state == MAC) && (k != K_END);

    fir_mac_unit #(
        .N    (N),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (coef[tap]),
        .b     (hist[newest - tap]),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            newest    <= '0;
            k         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (state == IDLE && coef_we) begin
                coef[coef_addr] <= coef_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hist[wr_ptr] <= in_data;
                        newest       <= wr_ptr;
                        wr_ptr       <= wr_ptr + AW'(1);
                        k            <= '0;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    // k reaching TAPS means the last product is already in acc.
                    if (k == K_END) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        k <= k + (AW+1)'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_mac.sv
// Bench for fir_tap_mac with TAPS=4: reference convolution feeds an expected queue,
// results are popped and compared on every output handshake.
module tb_fir_tap_mac;

    localparam int N    = 16;
    localparam int TAPS = 4;
    localparam int AW   = 2;
    localparam int ACCW = 2 * N + AW;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [N-1:0]    coef_data;
    logic [ACCW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      dbg_state;

    fir_tap_mac #(.N(N), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [ACCW-1:0] exp_q[$];
    logic [ACCW-1:0] last_out = '0;
    logic signed [N-1:0] hist_m [TAPS];
    logic signed [N-1:0] coef_m [TAPS];
    int              wp_m = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            hist_m[i] = '0;
            coef_m[i] = '0;
        end
        wp_m = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [N-1:0] x);
        longint s;
        hist_m[wp_m] = x;
        s = 0;
        for (int j = 0; j < TAPS; j++)
            s += longint'(coef_m[j]) * longint'(hist_m[(wp_m - j + TAPS) % TAPS]);
        wp_m = (wp_m + 1) % TAPS;
        exp_q.push_back(ACCW'(s));
    endtask

    // Output monitor: sample at the falling edge, the handshake completes at the next rise.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'hDEAD);
            end else begin
                check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            last_out = out_data;
        end
    end

    // ---------------- driver tasks (called at #1 after a rising edge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input logic [N-1:0] d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = d;
        @(posedge clk);
        coef_m[a] = d;
        #1;
        coef_we = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic send_sample(input logic [N-1:0] x);
        wait_ready();
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        model_accept(x);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        tick();

        // Impulse response: c = {1,2,3,4}, samples 1,0,0,0,0 -> 1,2,3,4,0
        for (int i = 0; i < TAPS; i++) write_coef(i, N'(i + 1));
        send_sample(16'd1);
        for (int i = 0; i < 4; i++) send_sample(16'd0);
        drain();
        check("impulse_last", 64'(last_out), 64'd0);

        // Signed extremes: every product is +2^30, sum 2^32 must not overflow
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'h8000);
        for (int i = 0; i < 4; i++) send_sample(16'h8000);
        drain();
        check("extreme_sum", 64'(last_out), 64'h1_0000_0000);

        // Back-pressure with latency check and ignored in_valid
        for (int i = 0; i < TAPS; i++) write_coef(i, N'(i + 1));
        out_ready = 1'b0;
        send_sample(16'd100);
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        check("latency", 64'(t), 64'(TAPS + 1));
        in_valid = 1'b1;
        in_data  = 16'd777;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_data", 64'(out_data), 64'(exp_q[0]));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_released_ready", 64'(in_ready), 64'd1);
        check("bp_released_valid", 64'(out_valid), 64'd0);

        // Coefficient write during MAC is dropped
        send_sample(16'd3);
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'd7;
        tick();
        coef_we = 1'b0;
        drain();

        // Same-cycle coefficient write and sample in IDLE: 7 * 2 = 14
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'd0);
        wait_ready();
        coef_we = 1'b1; coef_addr = '0; coef_data = 16'd7;
        in_valid = 1'b1; in_data = 16'd2;
        @(posedge clk);
        coef_m[0] = 16'd7;
        model_accept(16'd2);
        #1;
        coef_we = 1'b0; in_valid = 1'b0;
        drain();
        check("coef_same_cycle", 64'(last_out), 64'd14);

        // Wrap-around: c = {1,0,0,0}, samples 1..9 echo back
        write_coef(0, 16'd1);
        for (int i = 1; i <= 9; i++) send_sample(N'(i));
        drain();
        check("wrap_last", 64'(last_out), 64'd9);

        // Random coefficients and samples
        for (int i = 0; i < TAPS; i++) write_coef(i, N'($urandom_range(0, 65535)));
        for (int i = 0; i < 8; i++) send_sample(N'($urandom_range(0, 65535)));
        drain();

        // Reset in the middle of MAC (k = 2)
        send_sample(16'd9);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_state", 64'(dbg_state), 64'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < TAPS; i++) write_coef(i, 16'd1);
        send_sample(16'd5);
        drain();
        check("post_reset_impulse", 64'(last_out), 64'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
